// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down counter tracker.
package updown_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED   = 2'd0,
    ST_SYNC       = 2'd1,
    ST_TRACK_UP   = 2'd2,
    ST_TRACK_DOWN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STEP_UP   = 2'd0,
    STEP_DOWN = 2'd1,
    STEP_HOLD = 2'd2,
    STEP_BAD  = 2'd3
  } step_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_step_classify.sv
// Combinational classification of one count step (prev -> count_in).
module updown_step_classify
  import updown_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  output step_t            step,
  output logic             raw_wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] delta;

  // Modular difference decides the step class; wrap is the max<->0 boundary.
  always_comb begin
    delta = count_in - prev;
    if (delta == ONE)
      step = STEP_UP;
    else if (delta == '1)
      step = STEP_DOWN;
    else if (delta == '0)
      step = STEP_HOLD;
    else
      step = STEP_BAD;
    raw_wrap = ((prev == '1) && (count_in == '0)) ||
               ((prev == '0) && (count_in == '1));
  end

endmodule

// File: rtl/updown_count_tracker.sv
// Passive tracker of an up/down counter stream: direction inference,
// wrap / reversal / illegal-step detection and saturating error count.
module updown_count_tracker
  import updown_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] count_in,
  input  logic             cnt_rst_in,
  output logic             dir_out,
  output logic             locked,
  output logic             wrap,
  output logic             dir_change,
  output logic             step_err,
  output logic [ERRW-1:0]  err_cnt
);

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic             dir_n, wrap_n, chg_n, err_n;
  step_t            step;
  logic             raw_wrap;

  updown_step_classify #(.WIDTH(WIDTH)) u_classify (
    .prev     (prev),
    .count_in (count_in),
    .step     (step),
    .raw_wrap (raw_wrap)
  );

  // Next-state and next-output decode for one sample.
  always_comb begin
    state_n = state;
    prev_n  = prev;
    dir_n   = dir_out;
    wrap_n  = 1'b0;
    chg_n   = 1'b0;
    err_n   = 1'b0;
    if (valid_in) begin
      prev_n = count_in;
      if (cnt_rst_in) begin
        state_n = ST_SYNC;
        err_n   = (count_in != '0);
      end else begin
        // Any accepted UP/DOWN step outside UNLOCKED can report a wrap.
        if (state != ST_UNLOCKED)
          wrap_n = raw_wrap && ((step == STEP_UP) || (step == STEP_DOWN));
        unique case (state)
          ST_UNLOCKED: state_n = ST_SYNC;
          ST_SYNC: begin
            unique case (step)
              STEP_UP:   begin state_n = ST_TRACK_UP;   dir_n = DIR_UP;   end
              STEP_DOWN: begin state_n = ST_TRACK_DOWN; dir_n = DIR_DOWN; end
              STEP_HOLD: ;
              STEP_BAD:  err_n = 1'b1;
            endcase
          end
          ST_TRACK_UP: begin
            unique case (step)
              STEP_UP:   ;
              STEP_DOWN: begin state_n = ST_TRACK_DOWN; dir_n = DIR_DOWN; chg_n = 1'b1; end
              STEP_HOLD: ;
              STEP_BAD:  begin state_n = ST_SYNC; err_n = 1'b1; end
            endcase
          end
          ST_TRACK_DOWN: begin
            unique case (step)
              STEP_UP:   begin state_n = ST_TRACK_UP; dir_n = DIR_UP; chg_n = 1'b1; end
              STEP_DOWN: ;
              STEP_HOLD: ;
              STEP_BAD:  begin state_n = ST_SYNC; err_n = 1'b1; end
            endcase
          end
        endcase
      end
    end
  end

  // State, history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_UNLOCKED;
      prev       <= '0;
      dir_out    <= DIR_UP;
      wrap       <= 1'b0;
      dir_change <= 1'b0;
      step_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      dir_out    <= dir_n;
      wrap       <= wrap_n;
      dir_change <= chg_n;
      step_err   <= err_n;
      if (err_n && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

  assign locked = (state == ST_TRACK_UP) || (state == ST_TRACK_DOWN);

endmodule

// File: doc/updown_count_tracker.md
# updown_count_tracker

Passive tracker for the 4-bit up/down counter output stream: it consumes sampled `count` values plus the counter's reset sideband, infers the counting direction, and flags wrap-arounds, direction reversals and illegal steps. It sits beside the up/down counter in the datapath, or in a bench, as its reader/checker. It drives no signals back into the counter.

## Interface
- `WIDTH`, default 4: width of the tracked count.
- `ERRW`, default 8: width of the saturating error counter.
- `clk`  in  1: rising-edge clock, shared with the tracked counter.
- `rst`  in  1: synchronous, active-high reset of this block.
- `valid_in`  in  1: `count_in` and `cnt_rst_in` hold a new sample this cycle.
- `count_in`  in  WIDTH: sampled counter value.
- `cnt_rst_in`  in  1: the tracked counter was in reset for this sample.
- `dir_out`  out  1: inferred direction; 1 = up, 0 = down.
- `locked`  out  1: direction is established (TRACK_UP or TRACK_DOWN).
- `wrap`  out  1: one-cycle pulse on a legal wrap, either max->0 going up or 0->max going down.
- `dir_change`  out  1: one-cycle pulse on a legal direction reversal.
- `step_err`  out  1: one-cycle pulse on an illegal step.
- `err_cnt`  out  ERRW: saturating count of `step_err` pulses.

## Operation
- States: UNLOCKED (no previous sample), SYNC (previous sample held, direction unknown), TRACK_UP, TRACK_DOWN.
- Only cycles with `valid_in`=1 are evaluated. All other cycles hold state and outputs, and pulses return to 0.
- `prev` register holds the last accepted sample. It is updated on every valid sample, including erroneous ones.
- delta = (`count_in` − `prev`) mod 2^WIDTH, computed at WIDTH bits. The class of the step is:
  - UP: delta = 1.
  - DOWN: delta = 2^WIDTH−1.
  - HOLD: delta = 0.
  - BAD: any other delta.
- `cnt_rst_in`=1 takes priority in every state:
  - If `count_in`=0: go to SYNC, `prev`=0, no error.
  - If `count_in`≠0: `step_err`, then go to SYNC.
  - `dir_out` is unchanged.
- UNLOCKED + valid sample: latch `prev`, go to SYNC. Never flags an error.
- SYNC transitions:
  - UP: go to TRACK_UP, `dir_out`=1.
  - DOWN: go to TRACK_DOWN, `dir_out`=0.
  - HOLD: stay in SYNC.
  - BAD: `step_err`, stay in SYNC.
- TRACK_UP transitions:
  - UP: stay in TRACK_UP.
  - DOWN: `dir_change`, go to TRACK_DOWN, `dir_out`=0.
  - HOLD: stay.
  - BAD: `step_err`, go to SYNC, `dir_out` unchanged.
- TRACK_DOWN mirrors TRACK_UP.
- `wrap` is asserted on an accepted UP step with `prev`=2^WIDTH−1 and `count_in`=0, or an accepted DOWN step with `prev`=0 and `count_in`=2^WIDTH−1. This applies in SYNC and TRACK_*, including a step that also causes `dir_change`.
- `err_cnt` increments on each `step_err` and saturates at 2^ERRW−1.
- `locked` = 1 exactly when the state is TRACK_UP or TRACK_DOWN.

## Timing
- All outputs are registered. Response appears on the cycle after the `valid_in` sample edge, i.e. 1-cycle latency.
- `wrap`, `dir_change` and `step_err` are single-cycle pulses, even with back-to-back valid samples.
- `rst`=1 at a clock edge forces the following, regardless of `valid_in`:
  - state = UNLOCKED, `prev`=0.
  - `dir_out`=1.
  - `locked`, `wrap`, `dir_change`, `step_err` = 0.
  - `err_cnt`=0.
- A sample presented in the reset cycle is discarded.
- `rst` mid-track discards all history. The next valid sample only latches `prev`.
- `step_err` and `dir_change` are never asserted together. `wrap` may coincide with `dir_change`.

## Structure
- Shared package `updown_pkg` contains:
  - The state enum (UNLOCKED, SYNC, TRACK_UP, TRACK_DOWN).
  - The step-class enum (UP, DOWN, HOLD, BAD).
  - Constants `DIR_UP`=1 and `DIR_DOWN`=0.
- Sub-module `updown_step_classify`: purely combinational. Inputs are `prev` and `count_in`. Outputs are the step class and a raw wrap flag.
- The top level holds the FSM, the output registers and the saturating counter.

## Test plan
- Reset, then valid samples 0,1,2,3 → after the 3rd sample `locked`=1 and `dir_out`=1. No pulses. `err_cnt`=0.
- Up samples 14,15,0,1 → `wrap` is a single pulse one cycle after the 0 sample. The state stays TRACK_UP.
- Reversal 5,6,7,6,5 → `dir_change` pulses once, after the second 6 sample. `dir_out`=0, `locked` stays 1. Then down samples 1,0,15 → `wrap` pulses after the 15 sample.
- Jump 3,4,9 → `step_err` pulses after the 9 sample, `locked`=0, `err_cnt`=1. Then 10 → relocked up.
- Counter-reset sideband: a TRACK_UP stream at 7, then `cnt_rst_in`=1 with `count_in`=0 → no error, state SYNC. A second case with `cnt_rst_in`=1 and `count_in`=3 → `step_err` and `err_cnt` increments.
- Corner cases:
  - HOLD samples 4,4,4 in TRACK_DOWN → no pulses, state held.
  - `valid_in` gaps → no change.
  - Force 260 errors → `err_cnt`=255.
  - `rst` mid-stream → every output is at its reset value on the next cycle.
